// File: rtl/lsu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_pkg: shared state encoding and funct3 codes for the LSU          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    LOAD        = 3'd1,
    STORE_READ  = 3'd2,
    STORE_WRITE = 3'd3,
    RESP        = 3'd4
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores have no unsigned variants.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] funct3);
    logic ok;
    ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    if (!is_store) ok = ok || (funct3 == F3_BU) || (funct3 == F3_HU);
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_extend: selects and sign/zero-extends the loaded bytes          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module load_extend
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [3:0][7:0]  bytes,
  input  logic [2:0]       funct3,
  output logic [XLEN-1:0]  result
);

  always_comb begin
    result = '0;
    case (funct3)
      F3_B:    result = {{(XLEN-8){bytes[0][7]}}, bytes[0]};
      F3_H:    result = {{(XLEN-16){bytes[1][7]}}, bytes[1], bytes[0]};
      F3_W:    result = XLEN'(bytes);
      F3_BU:   result = XLEN'(bytes[0]);
      F3_HU:   result = XLEN'({bytes[1], bytes[0]});
      default: result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_store_controller: sequences loads, stores and sub-word RMW      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module load_store_controller
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned MEM_BYTES = 2**16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_is_store,
  input  logic [2:0]           req_funct3,
  input  logic [XLEN-1:0]      req_addr,
  input  logic [XLEN-1:0]      req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [XLEN-1:0]      resp_rdata,
  output logic                 resp_error,
  output logic                 mem_read_enable,
  output logic                 mem_write_enable,
  output logic [XLEN-1:0]      mem_read_addr,
  output logic [XLEN-1:0]      mem_write_addr,
  output logic [3:0][7:0]      mem_write_data,
  input  logic [3:0][7:0]      mem_read_data
);

  lsu_state_t        r_state, w_next_state;
  logic [2:0]        r_funct3;
  logic [XLEN-1:0]   r_addr;
  logic [15:0]       r_wdata_lo;
  logic [3:0][7:0]   r_merge;
  logic [XLEN-1:0]   r_rdata;
  logic              r_error;

  logic [XLEN:0]     w_end_addr;
  logic              w_req_err;
  logic [XLEN-1:0]   w_load_ext;

  // One extra bit keeps addr+4 from wrapping past zero.
  assign w_end_addr = {1'b0, req_addr} + (XLEN+1)'(4);
  assign w_req_err  = (w_end_addr > (XLEN+1)'(MEM_BYTES)) || !f3_legal(req_is_store, req_funct3);

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .bytes  (mem_read_data),
    .funct3 (r_funct3),
    .result (w_load_ext)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state     = r_state;
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_read_addr    = '0;
    mem_write_addr   = '0;
    mem_write_data   = '0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_req_err)               w_next_state = RESP;
          else if (!req_is_store)      w_next_state = LOAD;
          else if (req_funct3 == F3_W) w_next_state = STORE_WRITE;
          else                         w_next_state = STORE_READ;
        end
      end
      LOAD: begin
        mem_read_enable = 1'b1;
        mem_read_addr   = r_addr;
        w_next_state    = RESP;
      end
      STORE_READ: begin
        mem_read_enable = 1'b1;
        mem_read_addr   = r_addr;
        w_next_state    = STORE_WRITE;
      end
      STORE_WRITE: begin
        mem_write_enable = 1'b1;
        mem_write_addr   = r_addr;
        mem_write_data   = r_merge;
        w_next_state     = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_funct3   <= '0;
      r_addr     <= '0;
      r_wdata_lo <= '0;
      r_merge    <= '0;
      r_rdata    <= '0;
      r_error    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (req_valid) begin
          r_funct3   <= req_funct3;
          r_addr     <= req_addr;
          r_wdata_lo <= req_wdata[15:0];
          r_merge    <= req_wdata[31:0];
          r_rdata    <= '0;
          r_error    <= w_req_err;
        end
        LOAD: r_rdata <= w_load_ext;
        STORE_READ: begin
          // Later assignments override the matching bytes of the read window.
          r_merge    <= mem_read_data;
          r_merge[0] <= r_wdata_lo[7:0];
          if (r_funct3 == F3_H) r_merge[1] <= r_wdata_lo[15:8];
        end
        default: ;
      endcase
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_error = r_error;

endmodule
`default_nettype wire

// File: tb/tb_load_store_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_load_store_controller: directed bench with a byte memory model    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_load_store_controller;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned MEM_BYTES = 2**16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic             req_is_store;
  logic [2:0]       req_funct3;
  logic [XLEN-1:0]  req_addr;
  logic [XLEN-1:0]  req_wdata;
  logic             resp_valid;
  logic             resp_ready;
  logic [XLEN-1:0]  resp_rdata;
  logic             resp_error;
  logic             mem_read_enable;
  logic             mem_write_enable;
  logic [XLEN-1:0]  mem_read_addr;
  logic [XLEN-1:0]  mem_write_addr;
  logic [3:0][7:0]  mem_write_data;
  logic [3:0][7:0]  mem_read_data;

  int tests = 0;
  int fails = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  logic both_seen = 1'b0;

  logic [7:0]  mem [0:MEM_BYTES-1];
  logic [15:0] ra, wa;

  always #5 clk = ~clk;

  load_store_controller #(.XLEN(XLEN), .MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_error(resp_error),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_read_addr(mem_read_addr), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  assign ra = mem_read_addr[15:0];
  assign wa = mem_write_addr[15:0];
  assign mem_read_data = {mem[16'(ra + 16'd3)], mem[16'(ra + 16'd2)], mem[16'(ra + 16'd1)], mem[ra]};

  always @(posedge clk) begin
    if (mem_read_enable) rd_cnt <= rd_cnt + 1;
    if (mem_write_enable) begin
      wr_cnt <= wr_cnt + 1;
      for (int i = 0; i < 4; i++) mem[16'(wa + 16'(i))] <= mem_write_data[i];
    end
    if (mem_read_enable && mem_write_enable) both_seen <= 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for exactly one edge; returns just after that edge.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = d;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; resp_ready = 1'b1; req_valid = 1'b0;
    req_is_store = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
    repeat (3) step();
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    tests++; if (resp_valid !== 1'b0 || resp_error !== 1'b0) begin fails++; $display("FAIL reset_resp got v=%b e=%b exp 0 0", resp_valid, resp_error); end
    tests++; if ({mem_read_enable, mem_write_enable} !== 2'b00) begin fails++; $display("FAIL reset_enables got %b exp 00", {mem_read_enable, mem_write_enable}); end
    tests++; if ({mem_read_addr, mem_write_addr, resp_rdata, mem_write_data} !== 128'h0) begin fails++;
      $display("FAIL reset_data got ra=%h wa=%h rd=%h wd=%h exp 0", mem_read_addr, mem_write_addr, resp_rdata, mem_write_data); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_store_word();
    int r0;
    logic [31:0] a [2] = '{32'h100, 32'h200};
    logic [31:0] d [2] = '{32'h02017F80, 32'hDEADBEEF};
    for (int k = 0; k < 2; k++) begin
      r0 = rd_cnt;
      issue(1'b1, 3'b010, a[k], d[k]);
      tests++; if (mem_write_enable !== 1'b1 || mem_read_enable !== 1'b0 || mem_write_addr !== a[k] || mem_write_data !== d[k]) begin fails++;
        $display("FAIL sw_write got we=%b re=%b wa=%h wd=%h exp 1 0 %h %h", mem_write_enable, mem_read_enable, mem_write_addr, mem_write_data, a[k], d[k]); end
      step();
      tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0 || resp_error !== 1'b0 || rd_cnt != r0) begin fails++;
        $display("FAIL sw_resp got v=%b rd=%h e=%b reads=%0d exp 1 0 0 0", resp_valid, resp_rdata, resp_error, rd_cnt - r0); end
      step();
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b010};
    logic [31:0] a   [6] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h200};
    logic [31:0] exp [6] = '{32'hFFFFFF80, 32'h00000080, 32'h00007F80, 32'h00007F80, 32'h02017F80, 32'hDEADBEEF};
    for (int k = 0; k < 6; k++) begin
      issue(1'b0, f3[k], a[k], 32'h0);
      tests++; if (mem_read_enable !== 1'b1 || mem_read_addr !== a[k] || mem_write_enable !== 1'b0 || resp_valid !== 1'b0) begin fails++;
        $display("FAIL load%0d_access got re=%b ra=%h we=%b v=%b exp 1 %h 0 0", k, mem_read_enable, mem_read_addr, mem_write_enable, resp_valid, a[k]); end
      step();
      tests++; if (resp_valid !== 1'b1 || resp_rdata !== exp[k] || resp_error !== 1'b0) begin fails++;
        $display("FAIL load%0d_resp got v=%b rd=%h e=%b exp 1 %h 0", k, resp_valid, resp_rdata, resp_error, exp[k]); end
      step();
      tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL load%0d_idle got req_ready=%b exp 1", k, req_ready); end
    end
  endtask

  task automatic test_subword_store();
    logic [2:0]  f3   [2] = '{3'b000, 3'b001};
    logic [31:0] a    [2] = '{32'h100, 32'h101};
    logic [31:0] d    [2] = '{32'h123456AA, 32'h99995566};
    logic [31:0] wexp [2] = '{32'h02017FAA, 32'h00025566};
    logic [31:0] lexp [2] = '{32'h02017FAA, 32'h025566AA};
    for (int k = 0; k < 2; k++) begin
      issue(1'b1, f3[k], a[k], d[k]);
      tests++; if (mem_read_enable !== 1'b1 || mem_read_addr !== a[k] || mem_write_enable !== 1'b0) begin fails++;
        $display("FAIL rmw%0d_read got re=%b ra=%h we=%b exp 1 %h 0", k, mem_read_enable, mem_read_addr, mem_write_enable, a[k]); end
      step();
      tests++; if (mem_write_enable !== 1'b1 || mem_write_addr !== a[k] || mem_write_data !== wexp[k] || resp_valid !== 1'b0) begin fails++;
        $display("FAIL rmw%0d_write got we=%b wa=%h wd=%h v=%b exp 1 %h %h 0", k, mem_write_enable, mem_write_addr, mem_write_data, resp_valid, a[k], wexp[k]); end
      step();
      tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0 || resp_error !== 1'b0) begin fails++;
        $display("FAIL rmw%0d_resp got v=%b rd=%h e=%b exp 1 0 0", k, resp_valid, resp_rdata, resp_error); end
      step();
      issue(1'b0, 3'b010, 32'h100, 32'h0);
      step();
      tests++; if (resp_rdata !== lexp[k]) begin fails++; $display("FAIL rmw%0d_readback got %h exp %h", k, resp_rdata, lexp[k]); end
      step();
    end
  endtask

  task automatic test_errors();
    int r0, w0;
    logic        st  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3  [4] = '{3'b010, 3'b011, 3'b100, 3'b010};
    logic [31:0] a   [4] = '{32'(MEM_BYTES - 3), 32'h100, 32'h100, 32'hFFFFFFFE};
    for (int k = 0; k < 4; k++) begin
      r0 = rd_cnt; w0 = wr_cnt;
      issue(st[k], f3[k], a[k], 32'h5A5A5A5A);
      tests++; if (resp_valid !== 1'b1 || resp_error !== 1'b1 || resp_rdata !== 32'h0) begin fails++;
        $display("FAIL err%0d_resp got v=%b e=%b rd=%h exp 1 1 0", k, resp_valid, resp_error, resp_rdata); end
      step();
      tests++; if (rd_cnt != r0 || wr_cnt != w0 || req_ready !== 1'b1) begin fails++;
        $display("FAIL err%0d_noaccess got reads=%0d writes=%0d rdy=%b exp 0 0 1", k, rd_cnt - r0, wr_cnt - w0, req_ready); end
    end
    // Last legal window must not be flagged.
    issue(1'b0, 3'b010, 32'(MEM_BYTES - 4), 32'h0);
    tests++; if (mem_read_enable !== 1'b1 || resp_valid !== 1'b0) begin fails++;
      $display("FAIL edge_legal got re=%b v=%b exp 1 0", mem_read_enable, resp_valid); end
    step();
    tests++; if (resp_error !== 1'b0) begin fails++; $display("FAIL edge_legal_err got %b exp 0", resp_error); end
    step();
  endtask

  task automatic test_backpressure();
    int r0;
    r0 = rd_cnt;
    resp_ready = 1'b0;
    issue(1'b0, 3'b010, 32'h200, 32'h0);
    step();
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h300; req_wdata = 32'h11111111;
    for (int c = 0; c < 5; c++) begin
      tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF || req_ready !== 1'b0 || mem_read_enable !== 1'b0 || mem_write_enable !== 1'b0) begin fails++;
        $display("FAIL hold%0d got v=%b rd=%h rdy=%b re=%b we=%b exp 1 deadbeef 0 0 0", c, resp_valid, resp_rdata, req_ready, mem_read_enable, mem_write_enable); end
      step();
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    step();
    step();
    tests++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || rd_cnt != r0 + 1 || wr_cnt < 0) begin fails++;
      $display("FAIL hold_release got rdy=%b v=%b reads=%0d exp 1 0 1", req_ready, resp_valid, rd_cnt - r0); end
    tests++; if ({mem[16'h303], mem[16'h302], mem[16'h301], mem[16'h300]} !== 32'h0) begin fails++;
      $display("FAIL hold_ignored_req got mem300=%h exp 0", {mem[16'h303], mem[16'h302], mem[16'h301], mem[16'h300]}); end
  endtask

  task automatic test_reset_mid_op();
    int w0;
    w0 = wr_cnt;
    issue(1'b1, 3'b001, 32'h100, 32'h00001234);
    tests++; if (mem_read_enable !== 1'b1) begin fails++; $display("FAIL rstmid_in_read got re=%b exp 1", mem_read_enable); end
    rst_n = 1'b0;
    step();
    tests++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_write_enable !== 1'b0 || mem_read_enable !== 1'b0) begin fails++;
      $display("FAIL rstmid_idle got rdy=%b v=%b we=%b re=%b exp 1 0 0 0", req_ready, resp_valid, mem_write_enable, mem_read_enable); end
    rst_n = 1'b1;
    repeat (3) step();
    tests++; if (wr_cnt != w0 || resp_valid !== 1'b0) begin fails++; $display("FAIL rstmid_nowrite got writes=%0d v=%b exp 0 0", wr_cnt - w0, resp_valid); end
    tests++; if ({mem[16'h103], mem[16'h102], mem[16'h101], mem[16'h100]} !== 32'h025566AA) begin fails++;
      $display("FAIL rstmid_mem got %h exp 025566aa", {mem[16'h103], mem[16'h102], mem[16'h101], mem[16'h100]}); end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_loads();
    test_subword_store();
    test_errors();
    test_backpressure();
    test_reset_mid_op();
    tests++; if (both_seen !== 1'b0) begin fails++; $display("FAIL both_enables got %b exp 0", both_seen); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/load_store_controller.md
# load_store_controller

Sequences all data-memory traffic for the core. Accepts one load or store request at a time from the execute stage via a valid/ready handshake, and drives the byte-addressed data memory's read/write ports. Byte and halfword stores are performed as read-modify-write of the 4-byte window at the address. Returns sign- or zero-extended load data or an error through a response handshake.

## Interface
- XLEN, 32: datapath and address width
- MEM_BYTES, 2**16: data memory size in bytes; legal window is addr + 4 <= MEM_BYTES
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept (IDLE only)
- req_is_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, low bytes used for B/H
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors
- resp_error  out  1  illegal funct3 or out-of-range address
- mem_read_enable / mem_write_enable  out  1 each  memory port enables, never both high
- mem_read_addr / mem_write_addr  out  XLEN each  memory addresses, '0 when the matching enable is low
- mem_write_data  out  [3:0][7:0]  byte i goes to address mem_write_addr + i
- mem_read_data  in  [3:0][7:0]  combinational read, byte i from mem_read_addr + i

## Operation
- States: IDLE, LOAD, STORE_READ, STORE_WRITE, RESP.
- IDLE: req_ready=1. On req_valid, latch is_store, funct3, addr, and wdata.
  - Address or funct3 illegal -> RESP with error.
  - Load -> LOAD.
  - Store W -> STORE_WRITE, merge buffer = wdata.
  - Store B/H -> STORE_READ.
- Legal funct3: loads {000,001,010,100,101}; stores {000,001,010}. Anything else is an error.
- Range check: addr + 4 > MEM_BYTES is an error. Compute in XLEN+1 bits so the sum cannot wrap.
- LOAD: mem_read_enable=1, mem_read_addr=addr. Capture byte 0 (B/BU), bytes 1:0 (H/HU) or all 4 bytes (W). Sign-extend for 000/001, zero-extend for 100/101. -> RESP.
- STORE_READ: mem_read_enable=1. Capture mem_read_data into the merge buffer, then overwrite byte 0 (B) or bytes 1:0 (H) with wdata. -> STORE_WRITE.
- STORE_WRITE: mem_write_enable=1, mem_write_addr=addr, mem_write_data=merge buffer. -> RESP.
- RESP: resp_valid=1, outputs held stable. When resp_ready=1 -> IDLE.
- Errors perform no memory access of any kind.

## Timing
- Reset: state IDLE. req_ready=1 during reset cycles. resp_valid, resp_error, both enables, addresses, resp_rdata and mem_write_data all 0.
- Request accepted at edge N (IDLE, req_valid=1).
  - Load or SW: memory access in cycle N+1, resp_valid from N+2.
  - SB/SH: read in N+1, write in N+2, resp_valid from N+3.
  - Error: resp_valid from N+1.
- resp_ready high on the first RESP cycle: one RESP cycle, IDLE next. A back-to-back load or SW therefore has a 3-cycle throughput.
- req_valid while not IDLE is ignored; req_ready=0 outside IDLE.
- Reset asserted mid-operation: IDLE at next edge. The in-flight request is dropped with no response and no further memory access. A write already issued in STORE_WRITE stands.

## Structure
- Package lsu_pkg holds:
  - state enum lsu_state_t
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU
- Sub-module load_extend (combinational): bytes + funct3 -> extended XLEN result. Instantiated once in the LOAD path.

## Test plan
- Write memory 0x100..0x103 = 0x80,0x7F,0x01,0x02. LB 0x100 -> resp_rdata 0xFFFFFF80 at N+2. LBU -> 0x00000080. LH -> 0x00007F80. LW -> 0x02017F80.
- SB 0x100 with wdata 0xAA on the above contents -> read at N+1, write at N+2 of {0x02,0x01,0x7F,0xAA}. A following LW returns 0x02017FAA.
- SW 0x200 with 0xDEADBEEF -> single write at N+1, no read. LW 0x200 returns 0xDEADBEEF. Both responses have resp_rdata 0 and resp_error 0 for the store.
- LW at MEM_BYTES-3, then load with funct3 011 -> each gives resp_error=1 at N+1, no enable ever high.
- Hold resp_ready=0 for 5 cycles after a load -> resp_valid and resp_rdata stable, req_ready=0, a new req_valid is not accepted.
- Assert rst_n=0 during STORE_READ of an SH -> next cycle IDLE, no write, no resp_valid, memory unchanged.
